// File: rtl/cnn_maxpool.sv
// cnn_maxpool: streaming 2x2 / stride-2 max-pool with optional ReLU.
// Consumes raster-ordered pixels (channel, row, column; column fastest) from
// the convolution core and emits the pooled map in the same order.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-low reset
//   in_valid_i   input pixel valid
//   in_ready_o   input accepted when in_valid_i && in_ready_o
//   in_data_i    input pixel, signed DATA_W
//   out_valid_o  pooled pixel valid
//   out_ready_i  downstream accepts when out_valid_o && out_ready_i
//   out_data_o   pooled pixel, signed DATA_W
//   out_last_o   final pooled pixel of a frame
//   busy_o       a frame is in progress (first pixel in, last output not yet taken)
`timescale 1ns/1ps
module cnn_maxpool #(
  parameter int M_p    = 4,
  parameter int R_p    = 16,
  parameter int C_p    = 16,
  parameter int DATA_W = 16,
  parameter int RELU_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     out_last_o,
  output logic                     busy_o
);

  localparam int CW   = (C_p > 1) ? $clog2(C_p) : 1;
  localparam int RW   = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int MW   = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int LBW  = (C_p > 2) ? $clog2(C_p / 2) : 1;
  localparam int LB_N = 1 << LBW;

  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic [MW-1:0]            ch_q;
  logic signed [DATA_W-1:0] h_q;
  logic signed [DATA_W-1:0] lb [LB_N];

  logic                     in_fire;
  logic                     out_fire;
  logic                     col_last;
  logic                     row_last;
  logic                     ch_last;
  logic                     load;
  logic [LBW-1:0]           lb_idx;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] lb_max;
  logic signed [DATA_W-1:0] pooled;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_o && out_ready_i;
  assign col_last   = (col_q == CW'(C_p - 1));
  assign row_last   = (row_q == RW'(R_p - 1));
  assign ch_last    = (ch_q == MW'(M_p - 1));
  assign lb_idx     = LBW'(col_q >> 1);
  // A window completes on the odd-row, odd-column pixel.
  assign load       = in_fire && row_q[0] && col_q[0];

  always_comb begin
    h_max  = smax(h_q, in_data_i);
    lb_max = smax(lb[lb_idx], in_data_i);
    pooled = h_max;
    if (RELU_p != 0 && h_max[DATA_W-1]) pooled = '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      h_q         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (in_fire) begin
        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            row_q <= '0;
            ch_q  <= ch_last ? '0 : ch_q + MW'(1);
          end else begin
            row_q <= row_q + RW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
        // Even column opens a horizontal pair: plain load on even rows,
        // merge with the pair max stored from the row above on odd rows.
        if (!col_q[0]) h_q <= row_q[0] ? lb_max : in_data_i;
      end

      // A new load wins over the clear from acceptance in the same cycle.
      if (load) begin
        out_valid_o <= 1'b1;
        out_data_o  <= pooled;
        out_last_o  <= row_last && col_last && ch_last;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end

      if (in_fire)                     busy_o <= 1'b1;
      else if (out_fire && out_last_o) busy_o <= 1'b0;
    end
  end

  // Line buffer holds the horizontal pair max of each even row; every entry
  // is written before the odd row reads it, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (in_fire && !row_q[0] && col_q[0]) lb[lb_idx] <= h_max;
  end

endmodule

// File: doc/cnn_maxpool.md
Name: cnn_maxpool

Overview:
- Streaming 2x2, stride-2 max-pool stage with optional ReLU. Sits directly downstream of the cnn convolution core and consumes its output feature maps.
- Input: one output-map pixel per accepted beat, raster order (channel, then row, then column, column fastest).
- Output: the pooled map in the same raster order, M_p x R_p/2 x C_p/2 pixels per frame.
- Arithmetic: signed fixed point (synthesizable replacement for the floating-point model).

Parameters:
- M_p, 4: output channels per frame (cnn M_p).
- R_p, 16: input map rows; must be even, >=2.
- C_p, 16: input map columns; must be even, >=2.
- DATA_W, 16: pixel width, signed two's complement (Q8.8 by convention).
- RELU_p, 1: 1 = clamp pooled result to max(0, result); 0 = bypass.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  input pixel accepted when in_valid_i && in_ready_o.
- in_data_i  in  DATA_W  input pixel, signed.
- out_valid_o  out  1  pooled pixel valid.
- out_ready_i  in  1  downstream accepts when out_valid_o && out_ready_i.
- out_data_o  out  DATA_W  pooled pixel, signed.
- out_last_o  out  1  high with the final pooled pixel of a frame.
- busy_o  out  1  high while any pixel of the current frame has been accepted and the frame's last output has not yet been accepted.

Behaviour:
- Reset (reset_i low, asynchronous):
  - col/row/channel counters = 0; horizontal register h_q = 0.
  - out_valid_o = 0, out_data_o = 0, out_last_o = 0, busy_o = 0.
  - Line buffer is not reset; every entry is written before it is read.
- Ready: in_ready_o = !out_valid_o || out_ready_i (combinational). Stalls only while the output register holds an unaccepted pixel.
- Counters advance on each accepted input beat:
  - col 0..C_p-1; at wrap, row increments.
  - row 0..R_p-1; at wrap, channel increments.
  - channel 0..M_p-1; at wrap, all counters return to 0 and the next frame starts without a gap.
- Line buffer: C_p/2 entries x DATA_W, indexed by col>>1. Datapath per accepted pixel x:
  - Even row, even col: h_q <= x.
  - Even row, odd col: lb[col>>1] <= max(h_q, x).
  - Odd row, even col: h_q <= max(lb[col>>1], x).
  - Odd row, odd col: p = max(h_q, x); out_data_o <= RELU_p ? (p<0 ? 0 : p) : p; out_valid_o <= 1.
- Output flags:
  - out_last_o <= 1 with the output when row==R_p-1, col==C_p-1, channel==M_p-1; otherwise 0.
  - out_valid_o clears on acceptance unless a new pooled pixel loads in the same cycle (back-to-back load takes priority).
- max() is a signed comparison. Ties select either operand, since the values are identical. No width growth and no saturation needed.
- Latency: pooled pixel is visible one cycle after the bottom-right input of its 2x2 window is accepted.
- Throughput: 1 input/cycle sustained when out_ready_i is held high.
- Output stability: out_data_o and out_last_o hold stable while out_valid_o && !out_ready_i.
- Mid-frame reset: all state is discarded immediately; the next accepted pixel is treated as channel 0, row 0, col 0.
- busy_o: set on the first accepted pixel of a frame; cleared on acceptance of the out_last_o beat unless a new frame's first pixel is accepted in the same cycle.

Test Plan:
- Ramp, M_p=1, R_p=C_p=4, RELU_p=0, input value = row*4+col (Q8.8 integer, e.g. 5 = 0x0500), out_ready_i=1 -> outputs 5, 7, 13, 15 in order; out_last_o only on 15; each output one cycle after its bottom-right input.
- Negative values, RELU_p=1, every pixel = 0xFF00 (-1.0) -> all pooled outputs 0x0000. Same stimulus with RELU_p=0 -> all outputs 0xFF00.
- Max position, one 2x2 window = {0x0100, 0x0300, 0x0200, 0x8000} -> output 0x0300. Signed compare: 0x8000 must not win.
- Backpressure: hold out_ready_i=0 for 5 cycles when the first output appears -> in_ready_o=0 and out_data_o stable for those cycles. Release -> stream resumes; no pixel lost or duplicated.
- Multi-channel, back-to-back frames: M_p=2, R_p=C_p=4, two frames streamed continuously -> 16 outputs; out_last_o on outputs 8 and 16; counters wrap with no idle cycle.
- Mid-frame reset: assert reset_i low after 6 pixels, then send a full frame -> out_valid_o drops to 0 asynchronously; subsequent outputs match a clean frame exactly.
